// File: rtl/dm_burst_pkg.sv
// Shared types and AXI encodings for the burst master and its write buffer.
package dm_burst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW_W = 3'd3,
    ST_B    = 3'd4
  } dm_state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  function automatic logic resp_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/dm_wbuf_fifo.sv
// Power-of-two FIFO for write-through stores; also exposes each slot's key and
// occupancy so the master can check read/write address hazards.
module dm_wbuf_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int KEY_BITS = 4,
  localparam int PTR_BITS = $clog2(DEPTH),
  localparam int CNT_BITS = PTR_BITS + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       full,
  output logic                       empty,
  output logic [CNT_BITS-1:0]        count,
  output logic [DEPTH*KEY_BITS-1:0]  keys,
  output logic [DEPTH-1:0]           occupied
);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_BITS-1:0] rd_ptr_reg;
  logic [PTR_BITS-1:0] wr_ptr_reg;
  logic [CNT_BITS-1:0] count_reg;
  logic                do_push;
  logic                do_pop;

  assign full    = (count_reg == CNT_BITS'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_pop  = pop && !empty;
  // A pop frees the head slot, so a push into a full buffer lands in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  assign head_data = mem[rd_ptr_reg];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [PTR_BITS-1:0] offset;
      assign offset = PTR_BITS'(gi) - rd_ptr_reg;
      assign occupied[gi] = (CNT_BITS'(offset) < count_reg);
      assign keys[gi*KEY_BITS +: KEY_BITS] = mem[gi][WIDTH-1 -: KEY_BITS];
    end
  endgenerate

endmodule

// File: rtl/dm_burst_master.sv
// AXI4 master serving cache line fills and draining a write-through buffer,
// one transaction at a time, with reads held off while they alias buffered stores.
module dm_burst_master
  import dm_burst_pkg::*;
#(
  parameter int ID_BITS    = 4,
  parameter int ADDR_BITS  = 32,
  parameter int DATA_BITS  = 32,
  parameter int LINE_WORDS = 4,
  parameter int WBUF_DEPTH = 4,
  parameter int MASTER_ID  = 0,
  localparam int STRB_BITS = DATA_BITS / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_req,
  input  logic [ADDR_BITS-1:0]  rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_data_valid,
  output logic [DATA_BITS-1:0]  rd_data,
  output logic                  rd_last,
  input  logic                  wr_push,
  input  logic [ADDR_BITS-1:0]  wr_addr,
  input  logic [DATA_BITS-1:0]  wr_data,
  input  logic [STRB_BITS-1:0]  wr_strb,
  output logic                  wr_full,
  output logic                  wbuf_empty,
  output logic                  bus_err,
  output logic [ID_BITS-1:0]    arid,
  output logic [ADDR_BITS-1:0]  araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_BITS-1:0]  rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [ID_BITS-1:0]    awid,
  output logic [ADDR_BITS-1:0]  awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_BITS-1:0]  wdata,
  output logic [STRB_BITS-1:0]  wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  localparam int SIZE_LOG2  = $clog2(STRB_BITS);
  localparam int LINE_SHIFT = $clog2(LINE_WORDS * STRB_BITS);
  localparam int KEY_BITS   = ADDR_BITS - LINE_SHIFT;
  localparam int ENTRY_BITS = ADDR_BITS + DATA_BITS + STRB_BITS;
  localparam int CNT_BITS   = $clog2(WBUF_DEPTH) + 1;

  dm_state_t state_reg, state_next;

  logic [ADDR_BITS-1:0] rd_addr_reg;
  logic                 aw_done_reg, w_done_reg;
  logic                 rd_data_valid_reg, rd_last_reg, bus_err_reg;
  logic [DATA_BITS-1:0] rd_data_reg;

  logic [ENTRY_BITS-1:0]          head_entry;
  logic                           fifo_full, fifo_empty;
  logic [CNT_BITS-1:0]            fifo_count;
  logic [WBUF_DEPTH*KEY_BITS-1:0] wbuf_keys;
  logic [WBUF_DEPTH-1:0]          wbuf_occupied;
  logic [WBUF_DEPTH-1:0]          line_hit;

  logic hazard, accept_rd;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs, aw_w_done;

  // The line address sits in the top bits so the FIFO can expose it as the key.
  dm_wbuf_fifo #(
    .WIDTH    (ENTRY_BITS),
    .DEPTH    (WBUF_DEPTH),
    .KEY_BITS (KEY_BITS)
  ) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_push),
    .push_data ({wr_addr, wr_data, wr_strb}),
    .pop       (b_hs),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .keys      (wbuf_keys),
    .occupied  (wbuf_occupied)
  );

  generate
    for (genvar gi = 0; gi < WBUF_DEPTH; gi++) begin : g_hazard
      assign line_hit[gi] = wbuf_occupied[gi] &&
                            (wbuf_keys[gi*KEY_BITS +: KEY_BITS] == rd_addr[ADDR_BITS-1:LINE_SHIFT]);
    end
  endgenerate

  assign hazard    = |line_hit;
  assign accept_rd = (state_reg == ST_IDLE) && rd_req && !hazard && !rst;

  assign ar_hs     = arvalid && arready;
  assign r_hs      = rready && rvalid;
  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign b_hs      = bready && bvalid;
  assign aw_w_done = (aw_done_reg || aw_hs) && (w_done_reg || w_hs);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept_rd)        state_next = ST_AR;
        else if (!fifo_empty) state_next = ST_AW_W;
      end
      ST_AR:   if (ar_hs)          state_next = ST_R;
      ST_R:    if (r_hs && rlast)  state_next = ST_IDLE;
      ST_AW_W: if (aw_w_done)      state_next = ST_B;
      ST_B:    if (bvalid)         state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_gnt  = 1'b0;
    araddr  = '0;
    arlen   = '0;
    arsize  = '0;
    arburst = '0;
    arvalid = 1'b0;
    rready  = 1'b0;
    awaddr  = '0;
    awlen   = '0;
    awsize  = '0;
    awburst = '0;
    awvalid = 1'b0;
    wdata   = '0;
    wstrb   = '0;
    wlast   = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    case (state_reg)
      ST_IDLE: rd_gnt = accept_rd;
      ST_AR: begin
        arvalid = 1'b1;
        araddr  = rd_addr_reg;
        arlen   = 8'(LINE_WORDS - 1);
        arsize  = 3'(SIZE_LOG2);
        arburst = BURST_INCR;
      end
      ST_R: rready = 1'b1;
      ST_AW_W: begin
        awvalid = !aw_done_reg;
        wvalid  = !w_done_reg;
        awaddr  = head_entry[ENTRY_BITS-1 -: ADDR_BITS];
        awlen   = 8'd0;
        awsize  = 3'(SIZE_LOG2);
        awburst = BURST_INCR;
        wdata   = head_entry[STRB_BITS +: DATA_BITS];
        wstrb   = head_entry[STRB_BITS-1:0];
        wlast   = 1'b1;
      end
      ST_B: bready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_reg       <= '0;
      aw_done_reg       <= 1'b0;
      w_done_reg        <= 1'b0;
      rd_data_valid_reg <= 1'b0;
      rd_data_reg       <= '0;
      rd_last_reg       <= 1'b0;
      bus_err_reg       <= 1'b0;
    end else begin
      if (accept_rd) rd_addr_reg <= rd_addr;
      // Remember which half of the write already handshook until both have.
      aw_done_reg <= (state_reg == ST_AW_W) && !aw_w_done && (aw_done_reg || aw_hs);
      w_done_reg  <= (state_reg == ST_AW_W) && !aw_w_done && (w_done_reg || w_hs);
      rd_data_valid_reg <= r_hs;
      rd_last_reg       <= r_hs && rlast;
      if (r_hs) rd_data_reg <= rdata;
      bus_err_reg <= (r_hs && resp_err(rresp)) || (b_hs && resp_err(bresp));
    end
  end

  assign rd_data_valid = rd_data_valid_reg;
  assign rd_data       = rd_data_reg;
  assign rd_last       = rd_last_reg;
  assign bus_err       = bus_err_reg;
  assign wr_full       = fifo_full;
  assign wbuf_empty    = (fifo_count == '0) && (state_reg != ST_AW_W) && (state_reg != ST_B);
  assign arid          = ID_BITS'(MASTER_ID);
  assign awid          = ID_BITS'(MASTER_ID);

endmodule

// File: tb/tb_dm_burst_master.sv
// Directed bench for dm_burst_master: the bench plays the AXI slave cycle by cycle.
module tb_dm_burst_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_gnt, rd_data_valid, rd_last;
  logic [31:0] rd_data;
  logic        wr_push;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;
  logic        wr_full, wbuf_empty, bus_err;
  logic [3:0]  arid, awid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  dm_burst_master dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data), .rd_last(rd_last),
    .wr_push(wr_push), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_full(wr_full), .wbuf_empty(wbuf_empty), .bus_err(bus_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_push = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
    tick();
    wr_push = 1'b0;
  endtask

  // Serve one single-beat write; skew staggers the two READYs by two cycles.
  task automatic serve_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input bit skew, input bit aw_first, input logic [1:0] resp);
    int n = 0;
    while (!awvalid && n < 4) begin
      tick();
      n++;
    end
    $display("write: addr=%08h data=%08h strb=%h resp=%0d", a, d, s, resp);
    chk("aw_valid", awvalid, 1);
    chk("w_valid", wvalid, 1);
    chk("aw_addr", awaddr, a);
    chk("w_data", wdata, d);
    chk("w_strb", wstrb, s);
    chk("aw_len_last", {awlen, wlast, awburst}, {8'd0, 1'b1, 2'b01});
    if (skew) begin
      if (aw_first) awready = 1'b1; else wready = 1'b1;
      tick();
      awready = 1'b0; wready = 1'b0;
      chk("skew_first_drop", {awvalid, wvalid}, aw_first ? 2'b01 : 2'b10);
      tick();
      chk("skew_hold", {awvalid, wvalid, awaddr}, aw_first ? {2'b01, a} : {2'b10, a});
      if (aw_first) wready = 1'b1; else awready = 1'b1;
      tick();
      awready = 1'b0; wready = 1'b0;
    end else begin
      awready = 1'b1; wready = 1'b1;
      tick();
      awready = 1'b0; wready = 1'b0;
    end
    chk("b_ready", {bready, awvalid, wvalid}, 3'b100);
    bvalid = 1'b1; bresp = resp;
    tick();
    bvalid = 1'b0; bresp = 2'b00;
    chk("b_bus_err", bus_err, resp != 2'b00);
  endtask

  // Full line fill with one idle cycle after beat 1; err_beat gets RRESP=SLVERR.
  task automatic do_read(input logic [31:0] a, input logic [31:0] d0, input int err_beat);
    int n = 0;
    rd_req = 1'b1; rd_addr = a;
    #1;
    while (!rd_gnt && n < 8) begin
      tick();
      n++;
    end
    chk("rd_gnt", rd_gnt, 1);
    tick();
    rd_req = 1'b0;
    chk("ar_valid", arvalid, 1);
    chk("ar_addr", araddr, a);
    chk("ar_len_size_burst", {arlen, arsize, arburst}, {8'd3, 3'd2, 2'b01});
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("r_ready", {arvalid, rready}, 2'b01);
    for (int k = 0; k < 4; k++) begin
      rvalid = 1'b1; rdata = d0 + k; rlast = (k == 3);
      rresp = (k == err_beat) ? 2'b10 : 2'b00;
      tick();
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      $display("read beat %0d: addr=%08h data=%08h last=%0d", k, a, rd_data, rd_last);
      chk("rd_beat", {rd_data_valid, rd_last, rd_data}, {1'b1, k == 3, d0 + k});
      chk("rd_bus_err", bus_err, k == err_beat);
      if (k == 1) begin
        tick();
        chk("rd_stall", rd_data_valid, 0);
      end
    end
    tick();
    chk("rd_done", {rd_data_valid, rready, bus_err}, 3'b000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rd_req = 1'b0; rd_addr = '0;
    wr_push = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    arready = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = '0; bvalid = 1'b0;
    tick();
    tick();
    chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
    chk("rst_cache", {rd_gnt, rd_data_valid, rd_last, bus_err, wr_full, wbuf_empty}, 6'b000001);
    chk("rst_data", {rd_data, araddr}, 64'd0);
    rst = 1'b0;
    tick();

    // Plain line fill at 0x1000
    do_read(32'h1000, 32'hA0, -1);

    // Four buffered stores, drained in order with skewed READYs; fifth push dropped
    for (int i = 0; i < 4; i++) push(32'h2000 + 4 * i, 32'hD0 + i, 4'hF);
    chk("wr_full_after_4", wr_full, 1);
    push(32'h2010, 32'hDEAD, 4'hF);
    chk("wr_full_hold", {wr_full, wbuf_empty}, 2'b10);
    for (int i = 0; i < 4; i++) begin
      serve_write(32'h2000 + 4 * i, 32'hD0 + i, 4'hF, 1'b1, i[0], 2'b00);
      if (i == 0) chk("wr_full_after_pop", wr_full, 0);
    end
    chk("wbuf_empty_drained", wbuf_empty, 1);
    tick();
    tick();
    chk("no_extra_write", {awvalid, wbuf_empty}, 2'b01);

    // Read aliasing a buffered store waits for the store's B
    push(32'h1004, 32'h55, 4'h3);
    rd_req = 1'b1; rd_addr = 32'h1000;
    #1;
    chk("hazard_no_gnt", rd_gnt, 0);
    tick();
    chk("hazard_aw_first", {awvalid, arvalid, rd_gnt}, 3'b100);
    serve_write(32'h1004, 32'h55, 4'h3, 1'b0, 1'b0, 2'b00);
    chk("gnt_after_b", rd_gnt, 1);
    do_read(32'h1000, 32'hB0, 2);

    // Full buffer: push coincides with pop; then an error response mid-drain
    for (int i = 0; i < 4; i++) push(32'h3000 + 4 * i, 32'hE0 + i, 4'hC);
    chk("full_again", wr_full, 1);
    chk("head_3000", awaddr, 32'h3000);
    awready = 1'b1; wready = 1'b1;
    tick();
    awready = 1'b0; wready = 1'b0;
    chk("in_b", bready, 1);
    bvalid = 1'b1; wr_push = 1'b1; wr_addr = 32'h3010; wr_data = 32'hE4; wr_strb = 4'h1;
    tick();
    bvalid = 1'b0; wr_push = 1'b0;
    chk("full_after_push_pop", wr_full, 1);
    serve_write(32'h3004, 32'hE1, 4'hC, 1'b1, 1'b1, 2'b00);
    serve_write(32'h3008, 32'hE2, 4'hC, 1'b0, 1'b0, 2'b10);
    tick();
    chk("bus_err_pulse_end", bus_err, 0);
    serve_write(32'h300C, 32'hE3, 4'hC, 1'b0, 1'b0, 2'b00);
    serve_write(32'h3010, 32'hE4, 4'h1, 1'b0, 1'b0, 2'b00);
    chk("wbuf_empty_final", wbuf_empty, 1);

    // Reset in the middle of a fill with a store pending
    rd_req = 1'b1; rd_addr = 32'h6000;
    wr_push = 1'b1; wr_addr = 32'h5000; wr_data = 32'h77; wr_strb = 4'hF;
    #1;
    chk("rst_case_gnt", rd_gnt, 1);
    tick();
    rd_req = 1'b0; wr_push = 1'b0;
    arready = 1'b1;
    tick();
    arready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rvalid = 1'b1; rdata = 32'hC0 + k; rlast = 1'b0;
      tick();
    end
    chk("pre_rst_beat", {rd_data_valid, rd_data}, {1'b1, 32'hC1});
    chk("pre_rst_pending", wbuf_empty, 0);
    rdata = 32'hC2;
    rst = 1'b1;
    tick();
    $display("reset mid-fill: rready=%0d rd_data_valid=%0d wbuf_empty=%0d", rready, rd_data_valid, wbuf_empty);
    chk("mid_rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
    chk("mid_rst_cache", {rd_data_valid, rd_last, wr_full, wbuf_empty, rd_data}, {4'b0001, 32'd0});
    rst = 1'b0;
    tick();
    rvalid = 1'b0;
    chk("post_rst_no_beat", {rd_data_valid, rready, awvalid}, 3'b000);
    tick();
    chk("post_rst_idle", {rd_data_valid, arvalid, wbuf_empty}, 3'b001);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dm_burst_master.md
DM_BURST_MASTER -- requirements
Module: dm_burst_master

Interface
REQ-001 SHALL have parameter ID_BITS, default 4, AXI ID width.
REQ-002 SHALL have parameter ADDR_BITS, default 32, address width.
REQ-003 SHALL have parameter DATA_BITS, default 32, data width; STRB width = DATA_BITS/8.
REQ-004 SHALL have parameter LINE_WORDS, default 4, beats per read line fill; power of two, 1..16.
REQ-005 SHALL have parameter WBUF_DEPTH, default 4, write-buffer entries; power of two, >=2.
REQ-006 SHALL have parameter MASTER_ID, default 0, value driven on ARID/AWID.
REQ-007 SHALL have ports, clock and reset first:
 clk  in  1  sole clock, rising edge
 rst  in  1  synchronous, active-high reset
 rd_req  in  1  line-fill request, held until rd_gnt
 rd_addr  in  ADDR_BITS  line-aligned fill address
 rd_gnt  out  1  one-cycle pulse, request accepted
 rd_data_valid  out  1  fill beat valid
 rd_data  out  DATA_BITS  fill beat data
 rd_last  out  1  final fill beat
 wr_push  in  1  enqueue write-through store
 wr_addr / wr_data / wr_strb  in  ADDR_BITS / DATA_BITS / STRB  store contents
 wr_full  out  1  buffer full, push ignored
 wbuf_empty  out  1  no buffered or in-flight writes
 bus_err  out  1  one-cycle pulse on non-OKAY RRESP or BRESP
 AR*/R*/AW*/W*/B*  AXI4 master channels, ID/ADDR/LEN/SIZE/BURST/VALID/READY/DATA/STRB/LAST/RESP per AXI4.

Function
REQ-008 SHALL implement FSM states IDLE, AR, R, AW_W, B; one AXI transaction outstanding at a time.
REQ-009 IDLE priority: read (rd_req and no hazard) over write drain (buffer non-empty); otherwise stay IDLE.
REQ-010 Hazard: rd_req whose line address (addr >> log2(LINE_WORDS*STRB)) matches any buffered entry SHALL wait; writes drain until no match.
REQ-011 On read accept: rd_gnt pulses, address latched, state AR; ARVALID=1, ARLEN=LINE_WORDS-1, ARSIZE=log2(STRB), ARBURST=INCR; on ARREADY -> R.
REQ-012 In R: RREADY=1; each R handshake SHALL produce rd_data_valid/rd_data exactly one cycle later (registered); rd_last with the RLAST beat; RLAST handshake -> IDLE.
REQ-013 Write drain: head entry presented in AW_W with AWVALID and WVALID both asserted, AWLEN=0, WLAST=1, INCR; each VALID drops after its own handshake; both done -> B.
REQ-014 In B: BREADY=1; on BVALID the head entry SHALL be popped and state -> IDLE.
REQ-015 AXI VALID signals and payload SHALL stay stable until their handshake.
REQ-016 Buffer: FIFO order; wr_full = (count == WBUF_DEPTH); push while full and no pop SHALL be dropped; push and pop in the same cycle when full SHALL both take effect; pointers wrap modulo WBUF_DEPTH.
REQ-017 wbuf_empty = count==0 and state not in AW_W/B.
REQ-018 Non-OKAY RRESP on any beat or BRESP SHALL pulse bus_err next cycle; transaction completes normally, entry still popped.

Reset
REQ-019 rst high at a clock edge SHALL force IDLE, clear FIFO pointers/count, drive all VALID/READY, rd_gnt, rd_data_valid, rd_last and bus_err to 0, wr_full 0, wbuf_empty 1, data outputs 0.
REQ-020 Reset mid-transaction SHALL abandon it without completion; no partial beats reach the cache side afterwards.

Structure
REQ-021 FSM state enum, AXI BURST_INCR (2'b01), RESP_OKAY (2'b00) SHALL live in shared package dm_burst_pkg.
REQ-022 Write buffer SHALL be sub-module dm_wbuf_fifo (parametrised width/depth, push/pop/full/empty/count).

Verification
REQ-023 rd_req addr 0x0000_1000, LINE_WORDS=4, R data 0xA0..0xA3 -> ARLEN=3, four rd_data_valid beats 1 cycle after each R, rd_last on 0xA3.
REQ-024 Push 4 stores (0x2000..0x200C) with AWREADY/WREADY skewed 2 cycles -> four single-beat writes in order, wr_full high after 4th push, wbuf_empty high after last B.
REQ-025 Buffered store 0x1004, then rd_req 0x1000 -> AW for 0x1004 precedes AR; rd_gnt only after its BVALID.
REQ-026 Full buffer, push coinciding with BVALID pop -> count stays 4, new entry drained last.
REQ-027 BRESP=2'b10 on a write -> bus_err one-cycle pulse, entry popped, next entry proceeds.
REQ-028 rst asserted during R after beat 2 -> next cycle all VALID/READY 0, no further rd_data_valid, wbuf_empty 1.
